// File: rtl/vdot_unit.sv
// vdot_unit: multi-cycle packed-int8 dot-product engine for the EX stage.
// Each vector word takes three cycles: fetch A, fetch B, multiply-accumulate.
// Per-lane signed 8x8 products come from an array of vdot_lane instances.

// One int8 lane: signed 8x8 -> signed 16-bit product.
module vdot_lane (
   input  logic signed [7:0]  a,
   input  logic signed [7:0]  b,
   output logic signed [15:0] prod
);
   assign prod = a * b;
endmodule

module vdot_unit #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [31:0]      a_base,
   input  logic [31:0]      b_base,
   input  logic [LEN_W-1:0] len,
   output logic             mem_req,
   output logic [31:0]      mem_addr,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      result,
   output logic             done,
   output logic             busy,
   output logic             stall
);

   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      MAC  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [31:0]      a_ptr, b_ptr;
   logic [31:0]      a_word;
   logic [31:0]      acc, acc_nxt, dot;
   logic [LEN_W-1:0] cnt;
   logic             last_word;

   logic [NUM_LANES-1:0][2*VEC_W-1:0] prod;

   // During MAC, mem_rdata carries word B while a_word holds word A.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         vdot_lane u_lane (
            .a    (a_word[VEC_W*gi +: VEC_W]),
            .b    (mem_rdata[VEC_W*gi +: VEC_W]),
            .prod (prod[gi])
         );
      end
   endgenerate

   // Sign-extend each lane product and sum modulo 2^32.
   always_comb begin
      dot = '0;
      for (int i = 0; i < NUM_LANES; i++)
         dot = dot + {{(32-2*VEC_W){prod[i][2*VEC_W-1]}}, prod[i]};
      acc_nxt = acc + dot;
   end

   assign last_word = (cnt == LEN_W'(1));

   // Next-state and memory-port / handshake outputs.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_addr  = 32'd0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start && !flush)
               state_nxt = (len == '0) ? DONE : RD_A;
         end
         RD_A: begin
            mem_req   = 1'b1;
            mem_addr  = a_ptr;
            state_nxt = RD_B;
         end
         RD_B: begin
            mem_req   = 1'b1;
            mem_addr  = b_ptr;
            state_nxt = MAC;
         end
         MAC: begin
            state_nxt = last_word ? DONE : RD_A;
         end
         DONE: begin
            // A flush landing on the DONE cycle kills the writeback.
            done      = !flush;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush)
         state_nxt = IDLE;
   end

   assign busy  = (state != IDLE);
   assign stall = !rst && (((state == IDLE) && start && !flush) ||
                           (state == RD_A) || (state == RD_B) || (state == MAC));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath: operand latch, word capture, accumulate, result on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_ptr  <= '0;
         b_ptr  <= '0;
         a_word <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (!flush) begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_ptr <= a_base & ~32'h3;
                  b_ptr <= b_base & ~32'h3;
                  cnt   <= len;
                  acc   <= '0;
                  if (len == '0)
                     result <= '0;
               end
            end
            RD_B: a_word <= mem_rdata;
            MAC: begin
               acc   <= acc_nxt;
               a_ptr <= a_ptr + 32'd4;
               b_ptr <= b_ptr + 32'd4;
               cnt   <= cnt - LEN_W'(1);
               if (last_word)
                  result <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vdot_unit.sv
// Self-checking bench for vdot_unit: word-addressed memory model plus a
// plain-arithmetic dot-product reference.
module tb_vdot_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [31:0] a_base, b_base;
   logic [7:0]  len;
   logic        mem_req;
   logic [31:0] mem_addr, mem_rdata;
   logic [31:0] result;
   logic        done, busy, stall;

   int nvec  = 0;
   int nfail = 0;

   logic [31:0] mem [0:1023];
   logic [31:0] addr_q [$];

   vdot_unit #(.LEN_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush),
      .a_base(a_base), .b_base(b_base), .len(len),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .result(result), .done(done), .busy(busy), .stall(stall)
   );

   always #5 clk = ~clk;

   // Memory: one-cycle read latency; garbage on the bus when not requested.
   always @(posedge clk) begin
      if (mem_req) begin
         addr_q.push_back(mem_addr);
         mem_rdata <= mem[mem_addr[11:2]];
      end else begin
         mem_rdata <= $urandom;
      end
   end

   function automatic logic [31:0] ref_dot(input logic [31:0] ab, input logic [31:0] bb, input int n);
      logic [31:0] s, pa, pb, wa, wb;
      int p;
      s = 0; pa = ab & ~32'h3; pb = bb & ~32'h3;
      for (int k = 0; k < n; k++) begin
         wa = mem[pa[11:2]];
         wb = mem[pb[11:2]];
         for (int l = 0; l < 4; l++) begin
            p = $signed(wa[8*l +: 8]) * $signed(wb[8*l +: 8]);
            s = s + p;
         end
         pa = pa + 4; pb = pb + 4;
      end
      return s;
   endfunction

   // Call at the negedge of the cycle that is to be cycle 0 (start sampled at its end).
   task automatic run_op(input logic [31:0] ab, input logic [31:0] bb, input logic [7:0] n,
                         input bit hold, output logic [31:0] res);
      int exp_d;
      logic [31:0] exp_r, pa, pb;
      logic [31:0] exp_a [$];
      bit addr_ok;
      exp_d = (n == 0) ? 1 : 3 * n + 1;
      exp_r = ref_dot(ab, bb, int'(n));
      res = 'x;
      a_base = ab; b_base = bb; len = n; start = 1'b1;
      addr_q.delete();
      #1;
      nvec++;
      if (stall !== 1'b1) begin nfail++; $display("FAIL stall_c0 got %b exp 1", stall); end
      for (int cyc = 1; cyc <= exp_d; cyc++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         nvec++;
         if (stall !== (cyc < exp_d)) begin
            nfail++; $display("FAIL stall cyc %0d got %b exp %b", cyc, stall, cyc < exp_d);
         end
         nvec++;
         if (done !== (cyc == exp_d) || busy !== 1'b1) begin
            nfail++; $display("FAIL done_busy cyc %0d got done=%b busy=%b exp done=%b busy=1",
                              cyc, done, busy, cyc == exp_d);
         end
         if (cyc == exp_d) begin
            res = result;
            nvec++;
            if (result !== exp_r) begin
               nfail++; $display("FAIL result len %0d got %h exp %h", n, result, exp_r);
            end
         end
      end
      pa = ab & ~32'h3; pb = bb & ~32'h3;
      for (int k = 0; k < n; k++) begin
         exp_a.push_back(pa); exp_a.push_back(pb);
         pa = pa + 4; pb = pb + 4;
      end
      addr_ok = (addr_q.size() == exp_a.size());
      if (addr_ok)
         for (int k = 0; k < exp_a.size(); k++)
            if (addr_q[k] !== exp_a[k]) addr_ok = 0;
      nvec++;
      if (!addr_ok) begin
         nfail++; $display("FAIL addr_seq got %0d reqs (first %h) exp %0d reqs (first %h)",
                           addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'h0,
                           exp_a.size(), (exp_a.size() > 0) ? exp_a[0] : 32'h0);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; flush = 1'b0; a_base = 0; b_base = 0; len = 8'd1;
      repeat (3) @(negedge clk);
      nvec++;
      if ({result, mem_addr} !== 64'd0 || {mem_req, done, busy, stall} !== 4'd0) begin
         nfail++; $display("FAIL reset got res=%h addr=%h req=%b done=%b busy=%b stall=%b exp all 0",
                           result, mem_addr, mem_req, done, busy, stall);
      end
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [31:0] r;
      mem[16] = 32'h01020304; mem[32] = 32'h01010101;
      run_op(32'h40, 32'h80, 8'd1, 0, r);
      nvec++;
      if (r !== 32'h0000000A) begin nfail++; $display("FAIL basic got %h exp 0000000a", r); end
      @(negedge clk);
   endtask

   task automatic test_signed;
      logic [31:0] r;
      mem[48] = 32'h80FF7F01; mem[49] = 32'h80FF7F01;
      run_op(32'hC0, 32'hC4, 8'd1, 0, r);
      nvec++;
      if (r !== 32'h00007F03) begin nfail++; $display("FAIL signed got %h exp 00007f03", r); end
      @(negedge clk);
   endtask

   task automatic test_len0;
      logic [31:0] r;
      run_op(32'h40, 32'h80, 8'd0, 0, r);
      nvec++;
      if (r !== 32'h0) begin nfail++; $display("FAIL len0 got %h exp 0", r); end
      @(negedge clk);
   endtask

   task automatic test_align;
      logic [31:0] r;
      run_op(32'h103, 32'h200, 8'd3, 0, r);
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [31:0] r;
      for (int t = 0; t < 8; t++) begin
         run_op($urandom, $urandom, 8'($urandom_range(1, 20)), 0, r);
         @(negedge clk);
      end
      // Pointers wrapping past 2^32.
      run_op(32'hFFFFFFF9, 32'hFFFFFFF4, 8'd4, 0, r);
      @(negedge clk);
      // Maximum length.
      run_op($urandom, $urandom, 8'd255, 0, r);
      @(negedge clk);
   endtask

   task automatic test_flush;
      logic [31:0] prev;
      prev = result;
      a_base = 32'h300; b_base = 32'h340; len = 8'd4; start = 1'b1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      // cycle 6 is MAC of word 2
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      nvec++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
         nfail++; $display("FAIL flush got busy=%b done=%b res=%h exp busy=0 done=0 res=%h",
                           busy, done, result, prev);
      end
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         nvec++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            nfail++; $display("FAIL flush_quiet got done=%b busy=%b exp 0", done, busy);
         end
      end
      // flush beats start in IDLE
      start = 1'b1; flush = 1'b1;
      #1;
      nvec++;
      if (stall !== 1'b0) begin nfail++; $display("FAIL flush_prio_stall got %b exp 0", stall); end
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      nvec++;
      if (busy !== 1'b0) begin nfail++; $display("FAIL flush_prio_busy got %b exp 0", busy); end
   endtask

   task automatic test_rst_mid;
      logic [31:0] r;
      mem[100] = 32'h05050505; mem[101] = 32'h03030303;
      run_op(32'h190, 32'h194, 8'd1, 0, r); // leaves a nonzero result
      @(negedge clk);
      a_base = 32'h190; b_base = 32'h194; len = 8'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;       // cycle 1: RD_A
      @(negedge clk);                      // cycle 2: RD_B
      rst = 1'b1;
      #1;
      nvec++;
      if (stall !== 1'b0) begin nfail++; $display("FAIL rst_stall got %b exp 0", stall); end
      @(negedge clk);
      nvec++;
      if ({result, mem_addr} !== 64'd0 || {mem_req, done, busy, stall} !== 4'd0) begin
         nfail++; $display("FAIL rst_mid got res=%h addr=%h req=%b done=%b busy=%b stall=%b exp all 0",
                           result, mem_addr, mem_req, done, busy, stall);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [31:0] r1, r2;
      run_op(32'h40, 32'h80, 8'd1, 1, r1);    // returns in DONE with start still high
      a_base = 32'h200; b_base = 32'h280; len = 8'd2;
      @(negedge clk);                          // IDLE cycle: cycle 0 of second op
      run_op(32'h200, 32'h280, 8'd2, 0, r2);
      @(negedge clk);
      nvec++;
      if (busy !== 1'b0) begin nfail++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      test_reset();
      test_basic();
      test_signed();
      test_len0();
      test_align();
      test_random();
      test_flush();
      test_rst_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
